// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised single-port RAM.
// The init-pattern function is kept wide so callers truncate to their own word width.
package ram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ram_state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    function automatic logic [63:0] init_value(input logic [63:0] base,
                                               input logic [63:0] step,
                                               input logic [63:0] idx);
        return base + idx * step;
    endfunction

endpackage

// File: rtl/ram_init_seq.sv
// Init sequencer: walks the word counter through 0..DEPTH-1 writing the
// arithmetic pattern, then parks in RUN until reset or a soft init request.
module ram_init_seq
    import ram_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 4,
    parameter int DEPTH     = 2**ADDR_W,
    parameter int INIT_BASE = 1,
    parameter int INIT_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_req,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic [DATA_W-1:0] init_data,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    ram_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (init_req) begin
            state_d = INIT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                INIT: begin
                    if (cnt_q == LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN:     state_d = RUN;
                default: state_d = INIT;
            endcase
        end
    end

    assign init_we   = (state_q == INIT);
    assign init_addr = cnt_q;
    assign init_data = DATA_W'(init_value(64'(INIT_BASE), 64'(INIT_STEP), 64'(cnt_q)));
    assign ready     = (state_q == RUN);

endmodule

// File: rtl/ram_sp_param.sv
// Single-port synchronous RAM with self-initialisation, ready-gated access,
// 1- or 2-cycle read latency and a sticky access-error flag.
module ram_sp_param
    import ram_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 4,
    parameter int DEPTH     = 2**ADDR_W,
    parameter int RD_LAT    = 1,
    parameter int INIT_BASE = 1,
    parameter int INIT_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              rw,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              init_req,
    output logic              ready,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              acc, in_range, wr_en, rd_en;
    logic [DATA_W-1:0] rd_word;

    logic [RD_LAT-1:0]             vld_pipe;
    logic [RD_LAT-1:0][DATA_W-1:0] dat_pipe;

    ram_init_seq #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .INIT_BASE (INIT_BASE),
        .INIT_STEP (INIT_STEP)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .init_req  (init_req),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .ready     (ready)
    );

    // A simultaneous init request swallows the access entirely, error included.
    assign acc      = cs & ~init_req;
    assign in_range = {1'b0, address} < DEPTH_L;
    assign wr_en    = acc & ready & (rw == RW_WRITE) & in_range;
    assign rd_en    = acc & ready & (rw == RW_READ);

    always_comb begin
        rd_word = '0;
        if (in_range) rd_word = mem[address];
    end

    always_ff @(posedge clk) begin
        if (init_we)    mem[init_addr] <= init_data;
        else if (wr_en) mem[address]   <= data_in;
    end

    // Valid bits shift toward the output; an init request kills everything in flight
    // and the data registers only advance behind a surviving valid, so data_out holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe <= ((vld_pipe & ~{RD_LAT{init_req}}) << 1) | RD_LAT'(rd_en);
            if (rd_en) dat_pipe[0] <= rd_word;
            for (int k = 1; k < RD_LAT; k++) begin
                if (vld_pipe[k-1] && !init_req) dat_pipe[k] <= dat_pipe[k-1];
            end
        end
    end

    assign data_out = dat_pipe[RD_LAT-1];
    assign rd_valid = vld_pipe[RD_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                err <= 1'b0;
        else if (init_req)                      err <= 1'b0;
        else if (acc && (!ready || !in_range))  err <= 1'b1;
    end

endmodule
